bidir_piso_tx: RTL

BIDIR_PISO_TX -- requirements
Module: bidir_piso_tx

---
 rtl/bidir_pkg.sv | 13 +
 rtl/bidir_piso_tx.sv | 98 +++++++++
 2 files changed

// File: rtl/bidir_pkg.sv
// Shared types for the bidirectional PISO transmitter.
// FSM states and shift-order encodings.
package bidir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic MODE_LSB_FIRST = 1'b0;
  localparam logic MODE_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bidir_piso_tx.sv
// Parallel-in serial-out transmitter, LSB- or MSB-first per frame.
// Back-to-back frames are gapless when a word is offered on the last bit.
module bidir_piso_tx
  import bidir_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             mode,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             accept;

  // Outputs decode purely from registered state.
  always_comb begin
    busy       = (state_q == SHIFT);
    s_valid    = busy;
    last       = busy && (cnt_q == LAST_CNT);
    load_ready = !busy || last;
    s_out      = 1'b0;
    if (busy) begin
      s_out = (mode_q == MODE_MSB_FIRST)
            ? shreg_q[WIDTH-1]
            : shreg_q[0];
    end
  end

  assign accept = load_valid && load_ready;

  // Next state: load on handshake, else shift toward the output end.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_d = '0;
          if (accept) begin
            shreg_d = load_data;
            mode_d  = mode;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (mode_q == MODE_MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear aborting any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSB_FIRST;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule
